// File: rtl/uart_tx_fifo_if.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_if
// Purpose : Bundles the CPU push side and the transmitter handshake side of
//           the UART transmit FIFO into one interface.
// Signals :
//   wr_en, wr_data          CPU push request and byte
//   full, empty, count      FIFO occupancy status
//   overflow                sticky "a push was dropped" flag
//   clear_overflow          clears overflow
//   uart_ready, uart_finish transmitter idle level / done pulse
//   uart_send, uart_data    start request level and byte to the transmitter
// Modports:
//   slave  - the FIFO itself (consumes pushes, drives status and uart_send/data)
//   master - the surrounding environment (CPU + transmitter)
// -----------------------------------------------------------------------------
interface uart_tx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
) ();

  logic                  wr_en;
  logic [7:0]            wr_data;
  logic                  full;
  logic                  empty;
  logic [DEPTH_LOG2:0]   count;
  logic                  overflow;
  logic                  clear_overflow;
  logic                  uart_ready;
  logic                  uart_finish;
  logic                  uart_send;
  logic [7:0]            uart_data;

  modport slave (
    input  wr_en, wr_data, clear_overflow, uart_ready, uart_finish,
    output full, empty, count, overflow, uart_send, uart_data
  );

  modport master (
    output wr_en, wr_data, clear_overflow, uart_ready, uart_finish,
    input  full, empty, count, overflow, uart_send, uart_data
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Purpose : Byte FIFO between the CPU store path and the UART byte transmitter.
//           Holds up to 2**DEPTH_LOG2 bytes and hands them one at a time to the
//           transmitter through its ready/send/finish handshake.
// Parameters:
//   DEPTH_LOG2  (1..8)   FIFO depth = 2**DEPTH_LOG2 entries
//   REQ_TIMEOUT (2..255) cycles a request waits for uart_ready to drop
// Ports:
//   Clock   system clock, all state on posedge
//   Reset   asynchronous, active-high reset
//   bus     uart_tx_fifo_if.slave: push side, status, transmitter handshake
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DEPTH_LOG2  = 4,
  parameter int REQ_TIMEOUT = 15
) (
  input  logic           Clock,
  input  logic           Reset,
  uart_tx_fifo_if.slave  bus
);

  localparam int                    CNT_W    = DEPTH_LOG2 + 1;
  localparam int                    DEPTH    = 2 ** DEPTH_LOG2;
  localparam logic [CNT_W-1:0]      DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0]      CNT_ZERO = CNT_W'(1'b0);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1'b1);
  localparam logic [7:0]            TMO_LAST = 8'(REQ_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_BUSY = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  state_s;
  logic [7:0]              mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr_r;
  logic [DEPTH_LOG2-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]        count_r;
  logic [CNT_W-1:0]        count_s;
  logic                    full_r;
  logic                    empty_r;
  logic                    overflow_r;
  logic                    overflow_s;
  logic                    send_r;
  logic                    send_s;
  logic [7:0]              data_r;
  logic [7:0]              data_s;
  logic [7:0]              tmo_r;
  logic [7:0]              tmo_s;
  logic                    push_s;
  logic                    drop_s;
  logic                    pop_s;

  // Push/pop qualification, next occupancy and sticky overflow.
  // full_r is the pre-edge value, so a push at full is dropped even if a pop
  // happens in the same cycle.
  always_comb begin
    push_s = bus.wr_en && !full_r;
    drop_s = bus.wr_en && full_r;
    pop_s  = (state_r == S_BUSY) && bus.uart_finish;

    case ({push_s, pop_s})
      2'b10:   count_s = count_r + CNT_ONE;
      2'b01:   count_s = count_r - CNT_ONE;
      default: count_s = count_r;
    endcase

    // A drop in the same cycle as a clear wins, so no drop goes unreported.
    if (drop_s) begin
      overflow_s = 1'b1;
    end else if (bus.clear_overflow) begin
      overflow_s = 1'b0;
    end else begin
      overflow_s = overflow_r;
    end
  end

  // Handshake FSM: next state, send level, presented byte and request timer.
  always_comb begin
    state_s = state_r;
    send_s  = send_r;
    data_s  = data_r;
    tmo_s   = tmo_r;
    case (state_r)
      S_IDLE: begin
        send_s = 1'b0;
        if (!empty_r && bus.uart_ready) begin
          data_s  = mem_r[rd_ptr_r];
          send_s  = 1'b1;
          tmo_s   = 8'd0;
          state_s = S_REQ;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_REQ: begin
        if (!bus.uart_ready) begin
          send_s  = 1'b0;
          state_s = S_BUSY;
        end else if (tmo_r == TMO_LAST) begin
          // Transmitter never took the byte: drop send for a cycle and retry
          // the same byte from S_IDLE; nothing is popped.
          send_s  = 1'b0;
          state_s = S_IDLE;
        end else begin
          tmo_s = tmo_r + 8'd1;
        end
      end
      S_BUSY: begin
        send_s = 1'b0;
        if (bus.uart_finish) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_BUSY;
        end
      end
      default: begin
        send_s  = 1'b0;
        state_s = S_IDLE;
      end
    endcase
  end

  // Control and status registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r    <= S_IDLE;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= CNT_ZERO;
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      overflow_r <= 1'b0;
      send_r     <= 1'b0;
      data_r     <= 8'h00;
      tmo_r      <= 8'd0;
    end else begin
      state_r    <= state_s;
      count_r    <= count_s;
      full_r     <= (count_s == DEPTH_C);
      empty_r    <= (count_s == CNT_ZERO);
      overflow_r <= overflow_s;
      send_r     <= send_s;
      data_r     <= data_s;
      tmo_r      <= tmo_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Byte storage; contents need no reset because the pointers gate validity.
  always_ff @(posedge Clock) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= bus.wr_data;
    end
  end

  assign bus.full      = full_r;
  assign bus.empty     = empty_r;
  assign bus.count     = count_r;
  assign bus.overflow  = overflow_r;
  assign bus.uart_send = send_r;
  assign bus.uart_data = data_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
// Purpose : Self-checking bench for uart_tx_fifo (depth 16, timeout 15).
//           A vector table covers basic push/send/pop behaviour; hand-written
//           sequences cover overflow, push-while-full with finish, pointer
//           wrap, request timeout, a transmitter model and reset mid-transfer.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int DL = 4;

  logic clk;
  logic rst;

  int n_checks;
  int n_fail;

  uart_tx_fifo_if #(.DEPTH_LOG2(DL)) bus ();

  uart_tx_fifo #(.DEPTH_LOG2(DL), .REQ_TIMEOUT(15)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       wr_en;
    logic [7:0] wr_data;
    logic       clr;
    logic       ready;
    logic       finish;
    logic [4:0] e_count;
    logic       e_full;
    logic       e_empty;
    logic       e_ovf;
    logic       e_send;
    logic [7:0] e_data;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full",  32'(bus.full), 32'd0);
    chk("rst_ovf",   32'(bus.overflow), 32'd0);
    chk("rst_send",  32'(bus.uart_send), 32'd0);
    chk("rst_data",  32'(bus.uart_data), 32'h00);
    bus.wr_en          = 1'b0;
    bus.wr_data        = 8'h00;
    bus.clear_overflow = 1'b0;
    bus.uart_ready     = 1'b0;
    bus.uart_finish    = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  // One complete request/accept/finish exchange from S_IDLE.
  task automatic xfer(input logic [7:0] exp);
    bus.uart_ready = 1'b1;
    tick();
    chk("xfer_send_hi", 32'(bus.uart_send), 32'd1);
    chk("xfer_data", 32'(bus.uart_data), 32'(exp));
    bus.uart_ready = 1'b0;
    tick();
    chk("xfer_send_lo", 32'(bus.uart_send), 32'd0);
    bus.uart_finish = 1'b1;
    tick();
    bus.uart_finish = 1'b0;
  endtask

  initial begin
    int         rises;
    int         sends;
    logic       prev_send;
    int         m_phase;
    int         m_cnt;
    logic [7:0] got [3];

    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    bus.wr_en          = 1'b0;
    bus.wr_data        = 8'h00;
    bus.clear_overflow = 1'b0;
    bus.uart_ready     = 1'b0;
    bus.uart_finish    = 1'b0;
    #2;
    do_reset();

    // wr_en, data, clr, ready, finish | count, full, empty, ovf, send, data
    vecs[0]  = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 8'hBB, 1'b0, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'hAA};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'hAA};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'hAA};
    vecs[5]  = '{1'b1, 8'hCC, 1'b0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'hAA};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'hBB};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'hBB};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'hBB};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hBB};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hBB};

    for (int i = 0; i < 11; i++) begin
      bus.wr_en          = vecs[i].wr_en;
      bus.wr_data        = vecs[i].wr_data;
      bus.clear_overflow = vecs[i].clr;
      bus.uart_ready     = vecs[i].ready;
      bus.uart_finish    = vecs[i].finish;
      tick();
      chk($sformatf("vec%0d_count", i), 32'(bus.count), 32'(vecs[i].e_count));
      chk($sformatf("vec%0d_full", i),  32'(bus.full), 32'(vecs[i].e_full));
      chk($sformatf("vec%0d_empty", i), 32'(bus.empty), 32'(vecs[i].e_empty));
      chk($sformatf("vec%0d_ovf", i),   32'(bus.overflow), 32'(vecs[i].e_ovf));
      chk($sformatf("vec%0d_send", i),  32'(bus.uart_send), 32'(vecs[i].e_send));
      chk($sformatf("vec%0d_data", i),  32'(bus.uart_data), 32'(vecs[i].e_data));
    end
    bus.wr_en = 1'b0; bus.clear_overflow = 1'b0; bus.uart_ready = 1'b0; bus.uart_finish = 1'b0;

    // Fill to full with uart_ready low, then overflow and its clear priority.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      push(8'(i));
      if (i == 14) begin
        chk("fill15_full", 32'(bus.full), 32'd0);
        chk("fill15_count", 32'(bus.count), 32'd15);
      end
    end
    chk("fill16_full", 32'(bus.full), 32'd1);
    chk("fill16_count", 32'(bus.count), 32'd16);
    chk("fill16_ovf", 32'(bus.overflow), 32'd0);
    push(8'hEE);
    chk("push17_ovf", 32'(bus.overflow), 32'd1);
    chk("push17_count", 32'(bus.count), 32'd16);
    tick();
    chk("ovf_sticky", 32'(bus.overflow), 32'd1);
    bus.wr_en = 1'b1; bus.wr_data = 8'hEF; bus.clear_overflow = 1'b1;
    tick();
    chk("ovf_set_beats_clr", 32'(bus.overflow), 32'd1);
    bus.wr_en = 1'b0;
    tick();
    chk("ovf_cleared", 32'(bus.overflow), 32'd0);
    bus.clear_overflow = 1'b0;

    // Push while full in the same cycle as uart_finish.
    bus.uart_ready = 1'b1;
    tick();
    chk("full_req_data", 32'(bus.uart_data), 32'h00);
    bus.uart_ready = 1'b0;
    tick();
    bus.wr_en = 1'b1; bus.wr_data = 8'h77; bus.uart_finish = 1'b1;
    tick();
    bus.wr_en = 1'b0; bus.uart_finish = 1'b0;
    chk("fullpop_count", 32'(bus.count), 32'd15);
    chk("fullpop_ovf", 32'(bus.overflow), 32'd1);
    chk("fullpop_full", 32'(bus.full), 32'd0);
    bus.uart_ready = 1'b1;
    tick();
    chk("fullpop_next_data", 32'(bus.uart_data), 32'h01);
    bus.uart_ready = 1'b0;

    // Same-cycle push and pop at count 5 with wr_ptr wrapping 15 -> 0.
    do_reset();
    for (int i = 0; i < 15; i++) push(8'(8'h10 + 8'(i)));
    for (int k = 0; k < 10; k++) xfer(8'(8'h10 + 8'(k)));
    chk("wrap_pre_count", 32'(bus.count), 32'd5);
    bus.uart_ready = 1'b1;
    tick();
    chk("wrap_req_data", 32'(bus.uart_data), 32'h1A);
    bus.uart_ready = 1'b0;
    tick();
    bus.wr_en = 1'b1; bus.wr_data = 8'h1F; bus.uart_finish = 1'b1;
    tick();
    bus.wr_en = 1'b0; bus.uart_finish = 1'b0;
    chk("pushpop_count", 32'(bus.count), 32'd5);
    push(8'h20);
    chk("wrap_push_count", 32'(bus.count), 32'd6);
    xfer(8'h1B); xfer(8'h1C); xfer(8'h1D); xfer(8'h1E); xfer(8'h1F); xfer(8'h20);
    chk("wrap_drain_count", 32'(bus.count), 32'd0);
    chk("wrap_drain_empty", 32'(bus.empty), 32'd1);

    // uart_ready stuck high: 15 cycles high, 1 low, re-raised with same byte.
    do_reset();
    bus.uart_ready = 1'b1;
    push(8'h5A);
    chk("tmo_push_send", 32'(bus.uart_send), 32'd0);
    tick();
    chk("tmo_first_send", 32'(bus.uart_send), 32'd1);
    chk("tmo_first_data", 32'(bus.uart_data), 32'h5A);
    for (int i = 1; i < 15; i++) begin
      tick();
      chk($sformatf("tmo_hold%0d", i), 32'(bus.uart_send), 32'd1);
    end
    tick();
    chk("tmo_drop", 32'(bus.uart_send), 32'd0);
    chk("tmo_drop_count", 32'(bus.count), 32'd1);
    tick();
    chk("tmo_retry_send", 32'(bus.uart_send), 32'd1);
    chk("tmo_retry_data", 32'(bus.uart_data), 32'h5A);
    chk("tmo_retry_count", 32'(bus.count), 32'd1);
    bus.uart_ready = 1'b0;

    // Three bytes through a transmitter model: ready drops 2 cycles after
    // send, finish pulses 20 cycles later, then ready returns.
    do_reset();
    push(8'h41); push(8'h42); push(8'h43);
    rises = 0; prev_send = 1'b0; m_phase = 0; m_cnt = 0;
    for (int i = 0; i < 3; i++) got[i] = 8'h00;
    for (int c = 0; c < 120; c++) begin
      bus.uart_ready  = (m_phase != 2);
      bus.uart_finish = (m_phase == 2) && (m_cnt == 20);
      tick();
      if (bus.uart_send && !prev_send) begin
        if (rises < 3) got[rises] = bus.uart_data;
        rises++;
      end
      prev_send = bus.uart_send;
      case (m_phase)
        0: if (bus.uart_send) begin m_phase = 1; m_cnt = 0; end
        1: begin m_cnt++; if (m_cnt == 2) begin m_phase = 2; m_cnt = 0; end end
        default: if (bus.uart_finish) begin m_phase = 0; m_cnt = 0; end else m_cnt++;
      endcase
    end
    bus.uart_finish = 1'b0;
    chk("model_sends", 32'(rises), 32'd3);
    chk("model_byte0", 32'(got[0]), 32'h41);
    chk("model_byte1", 32'(got[1]), 32'h42);
    chk("model_byte2", 32'(got[2]), 32'h43);
    chk("model_count", 32'(bus.count), 32'd0);

    // Reset in S_BUSY with 3 bytes queued discards everything.
    do_reset();
    push(8'h61); push(8'h62); push(8'h63);
    bus.uart_ready = 1'b1;
    tick();
    chk("busy_rst_req", 32'(bus.uart_send), 32'd1);
    bus.uart_ready = 1'b0;
    tick();
    do_reset();
    bus.uart_ready = 1'b1;
    sends = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.uart_send) sends++;
    end
    chk("busy_rst_no_send", 32'(sends), 32'd0);
    chk("busy_rst_count", 32'(bus.count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
